// File: rtl/wave_sched_ctrl.sv
// Table-driven sequencer for the waveform generator: LOAD/BLANK/RUN per entry, decimated sample mux.
// Optional per-entry output attenuation is enabled by defining WAVE_SCHED_ATTEN_EN.
module wave_sched_ctrl #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DWELL_W    = 24,
  parameter int unsigned BLANK_CYC  = 4,
  parameter int unsigned SAMPLE_DIV = 50,
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [2:0]         cfg_wave,
  input  logic [1:0]         cfg_sel,
  input  logic [1:0]         cfg_dc,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_last,
`ifdef WAVE_SCHED_ATTEN_EN
  input  logic [1:0]         cfg_atten,
`endif
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic signed [15:0] square_in,
  input  logic signed [15:0] saw_in,
  input  logic signed [15:0] trig_in,
  input  logic signed [15:0] sin_in,
  input  logic signed [15:0] ecg_in,
  output logic [1:0]         gen_sel,
  output logic [1:0]         gen_dc,
  output logic               gen_dc_in,
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  output logic [AW-1:0]      entry_idx,
  output logic               busy,
  output logic               done
);

  localparam int unsigned BW = $clog2(BLANK_CYC + 1);
  localparam int unsigned DW = $clog2(SAMPLE_DIV);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StBlank = 3'd2;
  localparam logic [2:0] StRun   = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]         tbl_wave  [DEPTH];
  logic [1:0]         tbl_sel   [DEPTH];
  logic [1:0]         tbl_dc    [DEPTH];
  logic [DWELL_W-1:0] tbl_dwell [DEPTH];
  logic               tbl_last  [DEPTH];

  logic [2:0]         state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [AW-1:0]      entry_idx_q;
  logic [1:0]         gen_sel_q, gen_dc_q;
  logic [2:0]         wave_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               last_q;
  logic [BW-1:0]      blank_q;
  logic [DW-1:0]      div_q;
  logic signed [15:0] sample_q;
  logic               valid_q;
  logic               do_adv, end_seq, load_hit, capture;
  logic signed [15:0] raw_sample, sel_sample;

`ifdef WAVE_SCHED_ATTEN_EN
  logic [1:0] tbl_atten [DEPTH];
  logic [1:0] atten_q;
`endif

  // Table has no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      tbl_wave[cfg_addr]  <= cfg_wave;
      tbl_sel[cfg_addr]   <= cfg_sel;
      tbl_dc[cfg_addr]    <= cfg_dc;
      tbl_dwell[cfg_addr] <= cfg_dwell;
      tbl_last[cfg_addr]  <= cfg_last;
`ifdef WAVE_SCHED_ATTEN_EN
      tbl_atten[cfg_addr] <= cfg_atten;
`endif
    end
  end

  assign load_hit = (state_q == StLoad) && (tbl_dwell[idx_q] != '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    do_adv  = 1'b0;
    end_seq = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d = StLoad;
          idx_d   = '0;
        end
      end
      StLoad: begin
        end_seq = tbl_last[idx_q] || (idx_q == AW'(DEPTH - 1));
        if (tbl_dwell[idx_q] == '0) do_adv = 1'b1;
        else                        state_d = StBlank;
      end
      StBlank: begin
        if (blank_q == BW'(BLANK_CYC - 1)) state_d = StRun;
      end
      StRun: begin
        end_seq = last_q || (idx_q == AW'(DEPTH - 1));
        if (dwell_q == DWELL_W'(1)) do_adv = 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (do_adv) begin
      if (end_seq) begin
        if (loop) begin
          state_d = StLoad;
          idx_d   = '0;
        end else begin
          state_d = StDone;
        end
      end else begin
        state_d = StLoad;
        idx_d   = idx_q + AW'(1);
      end
    end
    if (stop && (state_q != StIdle)) state_d = StIdle;
  end

  always_comb begin
    unique case (wave_q)
      3'd0:    raw_sample = square_in;
      3'd1:    raw_sample = saw_in;
      3'd2:    raw_sample = trig_in;
      3'd3:    raw_sample = sin_in;
      3'd4:    raw_sample = ecg_in;
      default: raw_sample = '0;
    endcase
`ifdef WAVE_SCHED_ATTEN_EN
    sel_sample = raw_sample >>> atten_q;
`else
    sel_sample = raw_sample;
`endif
  end

  // Capture one clock ahead so data and strobe leave the block aligned on RUN clock k*SAMPLE_DIV;
  // requiring the next state to be RUN drops a capture on the last RUN clock or on stop.
  assign capture = (state_q == StRun) && (state_d == StRun) && (div_q == DW'(SAMPLE_DIV - 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      entry_idx_q <= '0;
      gen_sel_q   <= '0;
      gen_dc_q    <= '0;
      wave_q      <= '0;
      dwell_q     <= '0;
      last_q      <= 1'b0;
      blank_q     <= '0;
      div_q       <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
`ifdef WAVE_SCHED_ATTEN_EN
      atten_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load_hit) begin
        entry_idx_q <= idx_q;
        gen_sel_q   <= tbl_sel[idx_q];
        gen_dc_q    <= tbl_dc[idx_q];
        wave_q      <= tbl_wave[idx_q];
        dwell_q     <= tbl_dwell[idx_q];
        last_q      <= tbl_last[idx_q];
`ifdef WAVE_SCHED_ATTEN_EN
        atten_q     <= tbl_atten[idx_q];
`endif
      end else if (state_q == StRun) begin
        dwell_q <= dwell_q - DWELL_W'(1);
      end
      blank_q <= (state_q == StBlank) ? blank_q + BW'(1) : '0;
      if (state_q == StRun) div_q <= (div_q == DW'(SAMPLE_DIV - 1)) ? '0 : div_q + DW'(1);
      else                  div_q <= '0;
      valid_q <= capture;
      if (capture)                                         sample_q <= sel_sample;
      else if ((state_d == StIdle) || (state_d == StBlank)) sample_q <= '0;
    end
  end

  assign gen_sel      = gen_sel_q;
  assign gen_dc       = gen_dc_q;
  assign gen_dc_in    = (state_q == StBlank) || (state_q == StRun);
  assign busy         = (state_q == StLoad) || (state_q == StBlank) || (state_q == StRun);
  assign done         = (state_q == StDone);
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign entry_idx    = entry_idx_q;

endmodule

// File: doc/wave_sched_ctrl.md
Name: wave_sched_ctrl

Overview:
Programmable sequencer for the waveform generator (square/saw/trig/sin/ECG, 50 MHz system clock).
- Steps through a small table of entries; each entry gives waveform, frequency select, duty/step select and dwell time.
- Drives the generator's sel/dc/dc_in controls and muxes the chosen signed 16-bit waveform onto one decimated sample stream for the downstream DAC/capture path.

Parameters:
DEPTH, 4, number of table entries (power of two, 2..16); AW = log2(DEPTH).
DWELL_W, 24, width of per-entry dwell counter, in clocks.
BLANK_CYC, 4, mute/settle clocks after each entry switch (>=1).
SAMPLE_DIV, 50, clocks per output sample strobe (>=2); 50 gives 1 MS/s.

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
cfg_we  in  1  table write strobe
cfg_addr  in  AW  table entry index
cfg_wave  in  3  0=square 1=saw 2=trig 3=sin 4=ecg; 5-7=mute
cfg_sel  in  2  generator frequency select
cfg_dc  in  2  generator duty/step select
cfg_dwell  in  DWELL_W  RUN clocks for this entry
cfg_last  in  1  entry ends the sequence
start  in  1  start pulse
stop  in  1  abort pulse
loop  in  1  level; 1 = wrap to entry 0 after the last entry
square_in, saw_in, trig_in, sin_in, ecg_in  in  16 signed  generator outputs
gen_sel  out  2  to generator sel
gen_dc  out  2  to generator dc
gen_dc_in  out  1  to generator dc_in (run enable)
sample_out  out  16 signed  muxed, registered sample
sample_valid  out  1  one-clock strobe
entry_idx  out  AW  active entry
busy  out  1  sequence in progress
done  out  1  one-clock completion pulse

Behaviour:
- Clock/reset: single clock clk. rst is synchronous and active-high.
- Reset values: all outputs 0, FSM=IDLE, table contents undefined (bench writes before use).
- Table writes: accepted in any state. A write to the active entry takes effect at that entry's next LOAD. A write and a LOAD to the same address in the same cycle: LOAD uses the old contents.
- FSM states: IDLE, LOAD, BLANK, RUN, DONE.
  - IDLE: gen_dc_in=0, sample_out=0, busy=0. start sampled high -> LOAD with idx=0.
  - LOAD (1 clk): latch entry[idx] into gen_sel/gen_dc/active wave/dwell counter; entry_idx=idx; busy=1.
    - dwell==0: skip the entry; apply the ADVANCE rule directly (no BLANK).
    - Otherwise -> BLANK.
  - BLANK (BLANK_CYC clks): gen_dc_in=1, sample_out forced 0, sample_valid=0 -> RUN.
  - RUN (exactly dwell clks): gen_dc_in=1.
    - Sample divider clears on RUN entry. sample_valid pulses on RUN clock SAMPLE_DIV, 2*SAMPLE_DIV, ...
    - sample_out is registered from the selected input in the same cycle sample_valid is high, and held otherwise.
    - Wave codes 5-7 give sample_out=0 with strobes still issued.
    - Last RUN clock -> ADVANCE.
  - ADVANCE rule:
    - If cfg_last is set or idx==DEPTH-1: loop=1 -> idx=0, LOAD; loop=0 -> DONE.
    - Otherwise idx+1, LOAD.
  - DONE (1 clk): done=1, busy=0, gen_dc_in=0 -> IDLE. gen_sel/gen_dc keep their last values.
- stop high in LOAD/BLANK/RUN/DONE -> IDLE next clock: gen_dc_in=0, sample_out=0, no done pulse.
- stop and start in the same clock: stop wins.
- start outside IDLE: ignored.
- All-entries-dwell-0 with loop=1: degenerate spin through LOADs is allowed; busy stays 1 until stop.
- Per-entry duration = 1 + BLANK_CYC + dwell clocks. Number of strobes per entry = floor(dwell/SAMPLE_DIV).

Optional Feature:
WAVE_SCHED_ATTEN_EN
- Defined: adds input cfg_atten[1:0], stored per entry. sample_out = selected sample arithmetic-shifted right by atten (sign preserved); -32768 >> 3 = -4096.
- Undefined: port and storage absent; sample_out is the unshifted input.

Test Plan:
1. rst high 5 clks with inputs toggling -> all outputs 0, busy=0, entry_idx=0; release, no start -> stays IDLE.
2. Entry0 {wave=3, sel=0, dc=2, dwell=1000, last=1}, loop=0, sin_in ramping, start pulse at cycle T -> gen_sel=0/gen_dc=2 from T+2; sample_out=0 for T+2..T+5; exactly 20 sample_valid pulses each matching sin_in; done=1 at T+1006; busy falls then.
3. Entries 0..2 {wave 0/1/2, dwell 200/0/100}, last on entry 2, loop=1 -> entry_idx sequence 0,2,0,2,...; entry 1 never reaches BLANK; 4 strobes per entry-0 visit, 2 per entry-2 visit; no done.
4. Stop pulse at RUN clock 500 of a 1000-clock entry -> next clock IDLE, gen_dc_in=0, sample_out=0, done never asserts; a new start restarts at entry 0.
5. start and stop high together in IDLE -> remains IDLE; start pulse during RUN -> no restart, entry_idx unchanged.
6. Entry with wave=6, dwell=100 -> 2 sample_valid pulses with sample_out=0; with WAVE_SCHED_ATTEN_EN, wave=4, atten=2, ecg_in=-1000 -> sample_out=-250.
